// File: rtl/rx_pkt_framer.sv
// Store-and-forward packet framer: writes fixed-length packets into a FIFO,
// commits only whole packets, and streams committed bytes out on AXI-Stream.
module rx_pkt_framer #(
   parameter int pPKT_LEN = 188,
   parameter int pFIFO_AW = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  idat,
   input  logic        ival,
   input  logic        isop,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic [15:0] pkt_cnt,
   output logic [15:0] drop_cnt
);

   localparam int PW      = pFIFO_AW + 1;
   localparam int DEPTH_N = 1 << pFIFO_AW;
   localparam int CW      = $clog2(pPKT_LEN);
   localparam logic [PW-1:0] DEPTH = {1'b1, {pFIFO_AW{1'b0}}};
   localparam logic [CW-1:0] LAST  = CW'(pPKT_LEN - 1);

   typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

   state_t                r_state, w_state_nx;
   logic [7:0]            r_mem [0:DEPTH_N-1];
   logic [PW-1:0]         r_wptr, r_cptr, r_rptr, r_fptr;
   logic [PW-1:0]         w_wptr_nx, w_cptr_nx;
   logic [CW-1:0]         r_wcnt, w_wcnt_nx, r_rcnt;
   logic [pFIFO_AW-1:0]   w_waddr;
   logic                  w_we, w_pkt_inc, w_drop_inc, w_full, w_start;
   logic [15:0]           r_pkt_cnt, r_drop_cnt;

   // read pipeline: stage A holds the RAM read, stage O drives the AXI outputs
   logic [7:0]            r_a_data, r_o_data;
   logic                  r_a_vld, r_a_user, r_a_last;
   logic                  r_o_vld, r_o_user, r_o_last;
   logic                  w_o_rdy, w_a_rdy, w_fetch, w_hs;

   // rptr advances only on handshake, so bytes in flight still count as occupied
   assign w_full  = (r_wptr - r_rptr) == DEPTH;
   assign w_start = ival & isop & ~w_full;

   always_comb begin
      w_state_nx = r_state;
      w_wptr_nx  = r_wptr;
      w_cptr_nx  = r_cptr;
      w_wcnt_nx  = r_wcnt;
      w_we       = 1'b0;
      w_waddr    = r_wptr[pFIFO_AW-1:0];
      w_pkt_inc  = 1'b0;
      w_drop_inc = 1'b0;
      case (r_state)
         IDLE, DROP: begin
            if (w_start) begin
               w_we       = 1'b1;
               w_waddr    = r_cptr[pFIFO_AW-1:0];
               w_wptr_nx  = r_cptr + PW'(1);
               w_wcnt_nx  = CW'(1);
               w_state_nx = FILL;
            end
         end
         FILL: begin
            if (ival) begin
               if (w_full) begin
                  w_wptr_nx  = r_cptr;
                  w_wcnt_nx  = '0;
                  w_drop_inc = 1'b1;
                  w_state_nx = DROP;
               end else if (isop) begin
                  // restart at the commit point; a partial packet is discarded
                  w_drop_inc = (r_wcnt != '0);
                  w_we       = 1'b1;
                  w_waddr    = r_cptr[pFIFO_AW-1:0];
                  w_wptr_nx  = r_cptr + PW'(1);
                  w_wcnt_nx  = CW'(1);
               end else begin
                  w_we      = 1'b1;
                  w_wptr_nx = r_wptr + PW'(1);
                  if (r_wcnt == LAST) begin
                     w_cptr_nx = r_wptr + PW'(1);
                     w_wcnt_nx = '0;
                     w_pkt_inc = 1'b1;
                  end else begin
                     w_wcnt_nx = r_wcnt + CW'(1);
                  end
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_wptr     <= '0;
         r_cptr     <= '0;
         r_wcnt     <= '0;
         r_pkt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_state <= w_state_nx;
         r_wptr  <= w_wptr_nx;
         r_cptr  <= w_cptr_nx;
         r_wcnt  <= w_wcnt_nx;
         if (w_pkt_inc && r_pkt_cnt != 16'hFFFF)
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
         if (w_drop_inc && r_drop_cnt != 16'hFFFF)
            r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign w_hs    = r_o_vld & m_axis_tready;
   assign w_o_rdy = ~r_o_vld | m_axis_tready;
   assign w_a_rdy = ~r_a_vld | w_o_rdy;
   assign w_fetch = (r_fptr != r_cptr) & w_a_rdy;

   always_ff @(posedge clk) begin
      if (w_we)
         r_mem[w_waddr] <= idat;
      if (w_fetch)
         r_a_data <= r_mem[r_fptr[pFIFO_AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fptr   <= '0;
         r_rptr   <= '0;
         r_rcnt   <= '0;
         r_a_vld  <= 1'b0;
         r_a_user <= 1'b0;
         r_a_last <= 1'b0;
         r_o_vld  <= 1'b0;
         r_o_user <= 1'b0;
         r_o_last <= 1'b0;
         r_o_data <= '0;
      end else begin
         if (w_hs)
            r_rptr <= r_rptr + PW'(1);
         if (w_a_rdy)
            r_a_vld <= w_fetch;
         if (w_fetch) begin
            r_fptr   <= r_fptr + PW'(1);
            r_a_user <= (r_rcnt == '0);
            r_a_last <= (r_rcnt == LAST);
            r_rcnt   <= (r_rcnt == LAST) ? '0 : r_rcnt + CW'(1);
         end
         if (w_o_rdy) begin
            r_o_vld <= r_a_vld;
            if (r_a_vld) begin
               r_o_data <= r_a_data;
               r_o_user <= r_a_user;
               r_o_last <= r_a_last;
            end
         end
      end
   end

   assign m_axis_tdata  = r_o_data;
   assign m_axis_tvalid = r_o_vld;
   assign m_axis_tuser  = r_o_user;
   assign m_axis_tlast  = r_o_last;
   assign pkt_cnt       = r_pkt_cnt;
   assign drop_cnt      = r_drop_cnt;

endmodule

// File: doc/rx_pkt_framer.md
RX_PKT_FRAMER -- requirements
Module: rx_pkt_framer

Interface
REQ-001 SHALL have parameter pPKT_LEN, default 188: bytes per packet; legal values >= 2.
REQ-002 SHALL have parameter pFIFO_AW, default 9: FIFO address width, depth 2^pFIFO_AW bytes.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is synchronous to it.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port idat, input, 8: decoded byte from the DeFEC output.
REQ-006 SHALL have port ival, input, 1: idat qualifier; the source has no backpressure.
REQ-007 SHALL have port isop, input, 1: frame start (finder_osop); valid only together with ival.
REQ-008 SHALL have port m_axis_tdata, output, 8: packet byte.
REQ-009 SHALL have port m_axis_tvalid, output, 1: output byte valid.
REQ-010 SHALL have port m_axis_tready, input, 1: sink ready.
REQ-011 SHALL have port m_axis_tlast, output, 1: last byte of a packet.
REQ-012 SHALL have port m_axis_tuser, output, 1: first byte of a packet.
REQ-013 SHALL have port pkt_cnt, output, 16: count of committed packets.
REQ-014 SHALL have port drop_cnt, output, 16: count of dropped partial packets.

Function
REQ-015 SHALL store bytes in a store-and-forward FIFO with write pointer wptr, commit pointer cptr and read pointer rptr, each pFIFO_AW+1 bits wide and wrapping modulo 2^(pFIFO_AW+1).
REQ-016 SHALL define FIFO full as wptr-rptr == 2^pFIFO_AW.
REQ-017 SHALL implement write FSM states IDLE, FILL and DROP, and SHALL enter IDLE on reset.
REQ-018 In IDLE, SHALL discard bytes without isop; on ival&isop it SHALL write the byte, set wcnt=1 and go to FILL.
REQ-019 In FILL, on ival & ~full & ~isop, SHALL write the byte and increment wcnt.
REQ-020 When the written byte has wcnt == pPKT_LEN-1 (before increment), SHALL in the same edge set cptr = new wptr, set wcnt=0, pkt_cnt++, and stay in FILL so that back-to-back packets need no isop.
REQ-021 In FILL, on ival&isop with wcnt != 0 and ~full, SHALL set wptr=cptr (rewind), drop_cnt++, write the byte at the old cptr, and set wcnt=1.
REQ-022 In FILL, on ival&isop with wcnt == 0, SHALL treat the byte as a normal first byte with no drop.
REQ-023 In FILL, on ival & full (with or without isop), SHALL rewind wptr=cptr, drop_cnt++ once, discard the byte, and go to DROP.
REQ-024 In DROP, SHALL discard bytes until ival & isop & ~full, then act as REQ-018.
REQ-025 pkt_cnt and drop_cnt SHALL saturate at 0xFFFF.
REQ-026 The read side SHALL read only entries in [rptr, cptr), so uncommitted bytes are never output.
REQ-027 The read side SHALL use registered outputs, and its read byte counter SHALL drive tuser (count 0) and tlast (count pPKT_LEN-1).
REQ-028 The first byte of a packet SHALL reach m_axis_tvalid exactly 2 clk after the commit edge when the output stage is empty.
REQ-029 SHALL sustain 1 byte/clk while m_axis_tready=1 and data is committed.
REQ-030 SHALL follow AXI-S rules: tdata, tlast and tuser stable while tvalid & ~tready; tvalid never drops without a handshake.
REQ-031 A write and a read in the same cycle SHALL both take effect; full SHALL be evaluated on pre-edge pointers.

Reset
REQ-032 rst=1 SHALL immediately clear wptr, cptr, rptr, wcnt, read counter, pkt_cnt and drop_cnt; force m_axis_tvalid, tlast, tuser and tdata to 0; and set FSM to IDLE.
REQ-033 rst asserted mid-packet SHALL lose all buffered data, with no partial output after release.

Verification (pPKT_LEN=4, pFIFO_AW=4)
REQ-034 SHALL cover: reset, then 5 bytes without isop -> no tvalid; pkt_cnt=0, drop_cnt=0.
REQ-035 SHALL cover: isop on 0x10, then contiguous 0x10..0x17 with tready=1 -> 8 bytes out in order; tuser on 0x10 and 0x14; tlast on 0x13 and 0x17; first tvalid 2 clk after the 0x13 write; pkt_cnt=2.
REQ-036 SHALL cover: isop on 0x20, byte 0x21, then isop on 0x30, bytes 0x30..0x33 -> only 0x30..0x33 out; drop_cnt=1.
REQ-037 SHALL cover: tready=0, isop then 20 bytes 0x00..0x13 -> 16 bytes committed; drop on 0x10; drop_cnt=1; DROP state. Then tready=1 -> 0x00..0x0F out with 4 tlast. Then isop on 0x40..0x43 -> packet output; pkt_cnt=5.
REQ-038 SHALL cover: tready toggling every cycle during scenario REQ-035 -> identical byte, tuser and tlast sequence with no duplicates.
REQ-039 SHALL cover: rst pulse while 2 bytes of a packet are buffered and 1 packet is pending output -> tvalid=0 in the same cycle; counters 0; after release, no output until a new isop.
